// File: rtl/beam_dir_pkg.sv
// Shared types for the doorway beam direction decoder.
// FSM state encoding and event bit indices.
package beam_dir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IN_A,
    ST_IN_AB,
    ST_IN_B,
    ST_OUT_B,
    ST_OUT_BA,
    ST_OUT_A,
    ST_FAULT
  } beam_state_t;

  localparam int EV_ENTRY = 0;
  localparam int EV_EXIT  = 1;

endpackage

// File: rtl/beam_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer.
// Level resets to 1 (beam clear) and moves after DEBOUNCE_CYCLES stable cycles.
module beam_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/beam_direction_decoder.sv
// Doorway entry/exit decoder with occupancy count and stretched events.
// Define BEAM_DIR_TIMEOUT_EN to build the per-state dwell timeout.
module beam_direction_decoder
  import beam_dir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int PULSE_CYCLES    = 2500000,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               beam_a_n,
  input  logic               beam_b_n,
  input  logic               count_clr,
  output logic [1:0]         event_o,
  output logic [COUNT_W-1:0] occupancy,
  output logic               fault_o
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);

  logic        deb_a;
  logic        deb_b;
  logic [1:0]  blk;
  beam_state_t state_q;
  beam_state_t nxt_path;
  beam_state_t nxt;
  logic        timeout_hit;
  logic [1:0]  stb;
  logic        fault_q;
  logic [COUNT_W-1:0] occ_q;
  logic [PW-1:0] str_q [2];

  beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (beam_a_n),
    .level (deb_a)
  );

  beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (beam_b_n),
    .level (deb_b)
  );

  // {A, B}, 1 = blocked
  assign blk = {~deb_a, ~deb_b};

  always_comb begin
    nxt_path = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (blk == 2'b10) nxt_path = ST_IN_A;
        if (blk == 2'b01) nxt_path = ST_OUT_B;
        if (blk == 2'b11) nxt_path = ST_FAULT;
      end
      ST_IN_A: begin
        if (blk == 2'b11) nxt_path = ST_IN_AB;
        if (blk == 2'b00) nxt_path = ST_IDLE;
        if (blk == 2'b01) nxt_path = ST_FAULT;
      end
      ST_IN_AB: begin
        if (blk == 2'b01) nxt_path = ST_IN_B;
        if (blk == 2'b10) nxt_path = ST_IN_A;
        if (blk == 2'b00) nxt_path = ST_IDLE;
      end
      ST_IN_B: begin
        if (blk == 2'b11) nxt_path = ST_IN_AB;
        if (blk == 2'b00) nxt_path = ST_IDLE;
        if (blk == 2'b10) nxt_path = ST_FAULT;
      end
      ST_OUT_B: begin
        if (blk == 2'b11) nxt_path = ST_OUT_BA;
        if (blk == 2'b00) nxt_path = ST_IDLE;
        if (blk == 2'b10) nxt_path = ST_FAULT;
      end
      ST_OUT_BA: begin
        if (blk == 2'b10) nxt_path = ST_OUT_A;
        if (blk == 2'b01) nxt_path = ST_OUT_B;
        if (blk == 2'b00) nxt_path = ST_IDLE;
      end
      ST_OUT_A: begin
        if (blk == 2'b11) nxt_path = ST_OUT_BA;
        if (blk == 2'b00) nxt_path = ST_IDLE;
        if (blk == 2'b01) nxt_path = ST_FAULT;
      end
      ST_FAULT: begin
        if (blk == 2'b00) nxt_path = ST_IDLE;
      end
      default: nxt_path = ST_IDLE;
    endcase
  end

  // A real transition wins over a timeout landing in the same cycle
  always_comb begin
    nxt = nxt_path;
    if (timeout_hit && nxt_path == state_q) nxt = ST_FAULT;
  end

  always_comb begin
    stb = '0;
    stb[EV_ENTRY] = (state_q == ST_IN_B)  && (blk == 2'b00);
    stb[EV_EXIT]  = (state_q == ST_OUT_A) && (blk == 2'b00);
  end

`ifdef BEAM_DIR_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  logic [DW-1:0] dwell_q;

  assign timeout_hit = (dwell_q == DW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q <= '0;
    end else if (nxt != state_q || state_q == ST_IDLE ||
                 state_q == ST_FAULT) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= nxt;
      fault_q <= (state_q == ST_FAULT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else if (count_clr) begin
      occ_q <= '0;
    end else if (stb[EV_ENTRY] && occ_q != '1) begin
      occ_q <= occ_q + 1'b1;
    end else if (stb[EV_EXIT] && occ_q != '0) begin
      occ_q <= occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        str_q[i] <= '0;
      end else if (stb[i]) begin
        str_q[i] <= PW'(PULSE_CYCLES);
      end else if (str_q[i] != '0) begin
        str_q[i] <= str_q[i] - 1'b1;
      end
    end
  end

  assign event_o[EV_ENTRY] = (str_q[EV_ENTRY] != '0);
  assign event_o[EV_EXIT]  = (str_q[EV_EXIT] != '0);
  assign occupancy = occ_q;
  assign fault_o   = fault_q;

endmodule
